// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: requester/owner tags and the default
// starvation threshold for the instruction port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IMEM   = 2'd1,
    OWN_DREAD  = 2'd2,
    OWN_DWRITE = 2'd3
  } owner_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Three-way arbiter (data write, data read, instruction read) in front of a
// single-port memory, with instruction anti-starvation and read-response routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int AW         = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              imem_ready,
  output logic                              imem_valid,
  input  logic [AW-1:0]                     imem_addr,
  output logic                              imem_rresp,
  output logic [31:0]                       imem_rdata,
  input  logic                              dmem_rready,
  output logic                              dmem_rvalid,
  input  logic [AW-1:0]                     dmem_raddr,
  output logic                              dmem_rresp,
  output logic [31:0]                       dmem_rdata,
  input  logic                              dmem_wready,
  output logic                              dmem_wvalid,
  input  logic [AW-1:0]                     dmem_waddr,
  input  logic [31:0]                       dmem_wdata,
  input  logic [3:0]                        dmem_wstrb,
  output logic                              mem_ready,
  input  logic                              mem_valid,
  output logic                              mem_we,
  output logic [AW-1:0]                     mem_addr,
  output logic [31:0]                       mem_wdata,
  output logic [3:0]                        mem_wstrb,
  input  logic                              mem_rresp,
  input  logic [31:0]                       mem_rdata,
  output owner_t                            dbg_owner,
  output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve,
  output logic                              dbg_spurious
);

  // Handshake: a requester raises its *_ready to ask for the memory and holds it;
  // the arbiter raises the matching *_valid in the same cycle to accept, and the
  // transfer happens in exactly the cycles where both are high.

  localparam int              SW           = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIMIT = SW'(STARVE_MAX);

  owner_t          gnt;
  owner_t          owner;
  logic [SW-1:0]   starve_cnt;
  logic            spurious_r;
  logic            starved;
  logic            rsp_live;

  assign starved = imem_ready && (starve_cnt == STARVE_LIMIT);

  // Write before data read keeps read-after-write order when both arrive together.
  always_comb begin
    gnt = OWN_NONE;
    if (!reset && mem_valid) begin
      if (starved)          gnt = OWN_IMEM;
      else if (dmem_wready) gnt = OWN_DWRITE;
      else if (dmem_rready) gnt = OWN_DREAD;
      else if (imem_ready)  gnt = OWN_IMEM;
    end
  end

  assign imem_valid  = (gnt == OWN_IMEM);
  assign dmem_rvalid = (gnt == OWN_DREAD);
  assign dmem_wvalid = (gnt == OWN_DWRITE);
  assign mem_ready   = (gnt != OWN_NONE);
  assign mem_we      = dmem_wvalid;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (gnt)
      OWN_IMEM:  mem_addr = imem_addr;
      OWN_DREAD: mem_addr = dmem_raddr;
      OWN_DWRITE: begin
        mem_addr  = dmem_waddr;
        mem_wdata = dmem_wdata;
        mem_wstrb = dmem_wstrb;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
      spurious_r <= 1'b0;
    end else begin
      if (!imem_ready || imem_valid)
        starve_cnt <= '0;
      else if (mem_valid && starve_cnt != STARVE_LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
      owner <= (gnt == OWN_IMEM || gnt == OWN_DREAD) ? gnt : OWN_NONE;
      if (mem_rresp && owner == OWN_NONE)
        spurious_r <= 1'b1;
    end
  end

  // A response landing during reset belongs to a read that is being abandoned.
  assign rsp_live   = mem_rresp && !reset;
  assign imem_rresp = rsp_live && (owner == OWN_IMEM);
  assign dmem_rresp = rsp_live && (owner == OWN_DREAD);
  assign imem_rdata = imem_rresp ? mem_rdata : '0;
  assign dmem_rdata = dmem_rresp ? mem_rdata : '0;

  assign dbg_owner    = owner;
  assign dbg_starve   = starve_cnt;
  assign dbg_spurious = spurious_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a short constrained-random
// burst, checked every cycle against a rule-level model with a response queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int SM = 4;
  localparam int SW = $clog2(SM + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_ready, imem_valid, imem_rresp;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          dmem_rready, dmem_rvalid, dmem_rresp;
  logic [AW-1:0] dmem_raddr;
  logic [31:0]   dmem_rdata;
  logic          dmem_wready, dmem_wvalid;
  logic [AW-1:0] dmem_waddr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          mem_ready, mem_valid, mem_we, mem_rresp;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  owner_t        dbg_owner;
  logic [SW-1:0] dbg_starve;
  logic          dbg_spurious;

  logic          inject_spur;
  logic [31:0]   rmem    [0:255];
  logic [31:0]   exp_mem [0:255];
  logic [33:0]   exp_q[$];
  int            m_starve;
  logic          m_spur;
  int            n_checks = 0;
  int            n_errors = 0;

  mem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rresp(imem_rresp), .imem_rdata(imem_rdata),
    .dmem_rready(dmem_rready), .dmem_rvalid(dmem_rvalid), .dmem_raddr(dmem_raddr),
    .dmem_rresp(dmem_rresp), .dmem_rdata(dmem_rdata),
    .dmem_wready(dmem_wready), .dmem_wvalid(dmem_wvalid), .dmem_waddr(dmem_waddr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rresp(mem_rresp), .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner), .dbg_starve(dbg_starve), .dbg_spurious(dbg_spurious)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder (one-cycle read latency) ----------------
  initial begin : responder
    logic        do_rd, do_wr, do_spur;
    logic [7:0]  rd_idx, wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
    mem_rresp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      do_rd   = mem_ready && mem_valid && !mem_we;
      do_wr   = mem_ready && mem_valid && mem_we;
      do_spur = inject_spur;
      rd_idx  = mem_addr[9:2];
      wr_idx  = mem_addr[9:2];
      wr_data = mem_wdata;
      wr_strb = mem_wstrb;
      @(posedge clk);
      mem_rresp <= do_rd || do_spur;
      mem_rdata <= do_rd ? rmem[rd_idx] : (do_spur ? 32'h5151_5151 : 32'h0);
      if (do_wr)
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) rmem[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // ---------------- model + per-cycle compare ----------------
  initial begin : compare
    owner_t      pend_own, g;
    logic [31:0] pend_data, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [33:0] ent;
    logic        live;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    m_starve = 0;
    m_spur   = 1'b0;
    forever begin
      @(negedge clk);
      pend_own  = OWN_NONE;
      pend_data = '0;
      if (exp_q.size() > 0) begin
        ent       = exp_q.pop_front();
        pend_own  = owner_t'(ent[33:32]);
        pend_data = ent[31:0];
      end
      chk("owner_reg", 32'(dbg_owner), 32'(pend_own));
      chk("starve_cnt", 32'(dbg_starve), 32'(m_starve));
      chk("spurious_flag", 32'(dbg_spurious), 32'(m_spur));

      // Who must win this cycle, from the priority rules.
      g = OWN_NONE;
      if (!reset && mem_valid) begin
        if (imem_ready && m_starve == SM) g = OWN_IMEM;
        else if (dmem_wready)             g = OWN_DWRITE;
        else if (dmem_rready)             g = OWN_DREAD;
        else if (imem_ready)              g = OWN_IMEM;
      end
      e_addr = '0; e_wdata = '0; e_wstrb = '0;
      if (g == OWN_IMEM)  e_addr = imem_addr;
      if (g == OWN_DREAD) e_addr = dmem_raddr;
      if (g == OWN_DWRITE) begin
        e_addr = dmem_waddr; e_wdata = dmem_wdata; e_wstrb = dmem_wstrb;
      end
      chk("imem_valid", 32'(imem_valid), 32'(g == OWN_IMEM));
      chk("dmem_rvalid", 32'(dmem_rvalid), 32'(g == OWN_DREAD));
      chk("dmem_wvalid", 32'(dmem_wvalid), 32'(g == OWN_DWRITE));
      chk("mem_ready", 32'(mem_ready), 32'(g != OWN_NONE));
      chk("mem_we", 32'(mem_we), 32'(g == OWN_DWRITE));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));

      live = !reset;
      chk("imem_rresp", 32'(imem_rresp), 32'(live && pend_own == OWN_IMEM));
      chk("imem_rdata", imem_rdata, (live && pend_own == OWN_IMEM) ? pend_data : 32'h0);
      chk("dmem_rresp", 32'(dmem_rresp), 32'(live && pend_own == OWN_DREAD));
      chk("dmem_rdata", dmem_rdata, (live && pend_own == OWN_DREAD) ? pend_data : 32'h0);

      if (reset) begin
        m_starve = 0;
        m_spur   = 1'b0;
        exp_q.delete();
      end else begin
        if (mem_rresp && pend_own == OWN_NONE) m_spur = 1'b1;
        if (!imem_ready || g == OWN_IMEM) m_starve = 0;
        else if (mem_valid && m_starve < SM) m_starve++;
        if (g == OWN_IMEM)  exp_q.push_back({g, exp_mem[imem_addr[9:2]]});
        if (g == OWN_DREAD) exp_q.push_back({g, exp_mem[dmem_raddr[9:2]]});
        if (g == OWN_DWRITE)
          for (int b = 0; b < 4; b++)
            if (dmem_wstrb[b]) exp_mem[dmem_waddr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- driver ----------------
  initial begin : driver
    logic aw, ar, ai;
    reset = 1'b1; mem_valid = 1'b1; inject_spur = 1'b0;
    imem_ready = 1'b1; imem_addr = 32'h8;
    dmem_rready = 1'b0; dmem_raddr = '0;
    dmem_wready = 1'b0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0;

    // Reset holds every grant low even with a request present.
    @(negedge clk);
    chk("rst_no_grant", 32'(imem_valid), 32'h0);
    chk("rst_mem_ready", 32'(mem_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("rst_owner", 32'(dbg_owner), 32'(OWN_NONE));
    tick();
    reset = 1'b0; imem_ready = 1'b0;
    tick();

    // All three requesting: write, then data read, then imem.
    dmem_wready = 1'b1; dmem_waddr = 32'h40; dmem_wdata = 32'hA1A2_A3A4; dmem_wstrb = 4'hF;
    dmem_rready = 1'b1; dmem_raddr = 32'h80;
    imem_ready = 1'b1; imem_addr = 32'h8;
    @(negedge clk);
    chk("prio_c0_write", 32'(dmem_wvalid), 32'h1);
    tick(); dmem_wready = 1'b0;
    @(negedge clk);
    chk("prio_c1_dread", 32'(dmem_rvalid), 32'h1);
    tick(); dmem_rready = 1'b0;
    @(negedge clk);
    chk("prio_c2_imem", 32'(imem_valid), 32'h1);
    chk("prio_dread_data", dmem_rdata, 32'hC0DE_0020);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    chk("prio_imem_data", imem_rdata, 32'hC0DE_0002);
    tick();

    // Data read hogging the port: imem must win on its fifth cycle of waiting.
    dmem_rready = 1'b1; dmem_raddr = 32'h84;
    imem_ready = 1'b1; imem_addr = 32'hC;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("starve_imem_grant", 32'(imem_valid), 32'(c == 4));
      if (c == 4) chk("starve_at_max", 32'(dbg_starve), 32'(SM));
      if (c == 5) chk("starve_cleared", 32'(dbg_starve), 32'h0);
      tick();
    end
    dmem_rready = 1'b0; imem_ready = 1'b0;
    tick();

    // Back-to-back imem reads.
    imem_ready = 1'b1; imem_addr = 32'h0;
    tick(); imem_addr = 32'h4;
    @(negedge clk);
    chk("b2b_rresp0", 32'(imem_rresp), 32'h1);
    chk("b2b_rdata0", imem_rdata, 32'hC0DE_0000);
    chk("b2b_dmem0", 32'(dmem_rresp), 32'h0);
    tick(); imem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_rresp1", 32'(imem_rresp), 32'h1);
    chk("b2b_rdata1", imem_rdata, 32'hC0DE_0001);
    chk("b2b_dmem1", 32'(dmem_rresp), 32'h0);
    tick();

    // Memory busy for three cycles.
    mem_valid = 1'b0;
    dmem_wready = 1'b1; dmem_waddr = 32'h44; dmem_wdata = 32'h55AA_55AA; dmem_wstrb = 4'h3;
    imem_ready = 1'b1; imem_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("busy_mem_ready", 32'(mem_ready), 32'h0);
      tick();
    end
    mem_valid = 1'b1;
    @(negedge clk);
    chk("busy_resume_write", 32'(dmem_wvalid), 32'h1);
    tick(); dmem_wready = 1'b0;
    @(negedge clk);
    chk("busy_resume_imem", 32'(imem_valid), 32'h1);
    tick(); imem_ready = 1'b0;
    tick();

    // Reset arrives while a data read response is due.
    dmem_rready = 1'b1; dmem_raddr = 32'h10;
    @(negedge clk);
    chk("rst_read_granted", 32'(dmem_rvalid), 32'h1);
    tick(); reset = 1'b1; dmem_rready = 1'b0;
    @(negedge clk);
    chk("rst_drop_rresp", 32'(dmem_rresp), 32'h0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_owner_none", 32'(dbg_owner), 32'(OWN_NONE));
    tick();

    // Write and read of the same address requested together.
    dmem_wready = 1'b1; dmem_waddr = 32'h100; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    dmem_rready = 1'b1; dmem_raddr = 32'h100;
    tick(); dmem_wready = 1'b0;
    tick(); dmem_rready = 1'b0;
    @(negedge clk);
    chk("raw_rresp", 32'(dmem_rresp), 32'h1);
    chk("raw_rdata", dmem_rdata, 32'hDEAD_BEEF);
    tick();

    // Partial strobe update of the same word.
    dmem_wready = 1'b1; dmem_wdata = 32'h1122_3344; dmem_wstrb = 4'b0101;
    dmem_rready = 1'b1;
    tick(); dmem_wready = 1'b0;
    tick(); dmem_rready = 1'b0;
    @(negedge clk);
    chk("strb_rdata", dmem_rdata, 32'hDE22_BE44);
    tick();

    // Response with no outstanding read.
    inject_spur = 1'b1;
    tick(); inject_spur = 1'b0;
    @(negedge clk);
    chk("spur_imem_blocked", 32'(imem_rresp), 32'h0);
    chk("spur_dmem_blocked", 32'(dmem_rresp), 32'h0);
    tick();
    @(negedge clk);
    chk("spur_flag_set", 32'(dbg_spurious), 32'h1);
    tick();

    // Random mix; requests stay up until accepted.
    for (int k = 0; k < 60; k++) begin
      mem_valid = ($urandom_range(0, 4) != 0);
      if (!dmem_wready && $urandom_range(0, 2) == 0) begin
        dmem_wready = 1'b1;
        dmem_waddr  = 32'($urandom_range(0, 63)) << 2;
        dmem_wdata  = $urandom;
        dmem_wstrb  = 4'($urandom_range(1, 15));
      end
      if (!dmem_rready && $urandom_range(0, 1) == 0) begin
        dmem_rready = 1'b1;
        dmem_raddr  = 32'($urandom_range(0, 63)) << 2;
      end
      if (!imem_ready && $urandom_range(0, 1) == 0) begin
        imem_ready = 1'b1;
        imem_addr  = 32'($urandom_range(0, 63)) << 2;
      end
      @(negedge clk);
      aw = dmem_wvalid; ar = dmem_rvalid; ai = imem_valid;
      tick();
      if (aw) dmem_wready = 1'b0;
      if (ar) dmem_rready = 1'b0;
      if (ai) imem_ready  = 1'b0;
    end
    dmem_wready = 1'b0; dmem_rready = 1'b0; imem_ready = 1'b0; mem_valid = 1'b1;
    tick();

    reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_spur_clear", 32'(dbg_spurious), 32'h0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
